// File: rtl/battle_pkg.sv
// Shared types and defaults for the battle move datapath sequencing.
// Holds the attack sequencer state encoding, frame index width and default limits.
package battle_pkg;

  localparam int FRAME_IDX_W      = 6;
  localparam int ATK_NUM_FRAMES   = 50;
  localparam int ATK_DRAW_TIMEOUT = 4096;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW0,
    S_WAIT,
    S_ERASE,
    S_STEP,
    S_DRAW,
    S_DONE
  } atk_state_t;

  // States in which the drawer is running a pass and the watchdog is armed.
  function automatic logic is_pass(atk_state_t s);
    return (s == S_DRAW0) || (s == S_ERASE) || (s == S_DRAW);
  endfunction

endpackage

// File: rtl/attack_sequencer_if.sv
// Handshake bundle between battle control, the frame/stepper/drawer datapath
// and the attack sequencer. The sequencer side uses the slave modport.
interface attack_sequencer_if;
  import battle_pkg::*;

  logic                   start;
  logic                   abort;
  logic                   frame_tick;
  logic                   draw_done;
  logic                   busy;
  logic                   anim_en;
  logic                   step_en;
  logic                   draw_en;
  logic                   erase;
  logic [FRAME_IDX_W-1:0] frame_idx;
  logic                   move_done;
  logic                   timeout;

  modport master (
    output start, abort, frame_tick, draw_done,
    input  busy, anim_en, step_en, draw_en, erase, frame_idx, move_done, timeout
  );

  modport slave (
    input  start, abort, frame_tick, draw_done,
    output busy, anim_en, step_en, draw_en, erase, frame_idx, move_done, timeout
  );

endinterface

// File: rtl/seq_watchdog.sv
// Pass watchdog: up-counter zeroed by clear, advanced by run; expired flags the
// last allowed cycle of a pass (count LIMIT-1 while still running).
module seq_watchdog #(
  parameter  int LIMIT = 4096,
  localparam int W     = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      cnt <= '0;
    else if (clear) cnt <= '0;
    else if (run)   cnt <= cnt + 1'b1;
  end

  assign expired = run && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/attack_sequencer.sv
// Moore sequencer for one sprite-attack move: draw, then per frame erase/step/draw.
// Define ATTACK_SEQ_ERASE_EN to include the erase pass before each step.
module attack_sequencer
  import battle_pkg::*;
#(
  parameter int NUM_FRAMES   = ATK_NUM_FRAMES,
  parameter int DRAW_TIMEOUT = ATK_DRAW_TIMEOUT
) (
  input  logic            clock,
  input  logic            reset,
  attack_sequencer_if.slave bus
);

  atk_state_t             state, state_next;
  logic [FRAME_IDX_W-1:0] frame_idx_q, idx_next;
  logic                   timeout_q, tmo_next;
  logic                   busy_q, step_q, draw_q, erase_q, done_q;
  logic                   wd_run, wd_expired;

  // Counter sits at zero outside passes, so every pass starts from a fresh count.
  assign wd_run = is_pass(state);

  seq_watchdog #(.LIMIT(DRAW_TIMEOUT)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (!wd_run),
    .run     (wd_run),
    .expired (wd_expired)
  );

  always_comb begin
    state_next = state;
    idx_next   = frame_idx_q;
    tmo_next   = timeout_q;
    if (state != S_IDLE && bus.abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          state_next = S_DRAW0;
          idx_next   = '0;
          tmo_next   = 1'b0;
        end
        S_DRAW0: begin
          if (bus.draw_done)   state_next = S_WAIT;
          else if (wd_expired) begin
            state_next = S_IDLE;
            tmo_next   = 1'b1;
          end
        end
        S_WAIT: if (bus.frame_tick) begin
`ifdef ATTACK_SEQ_ERASE_EN
          state_next = S_ERASE;
`else
          state_next = S_STEP;
`endif
        end
`ifdef ATTACK_SEQ_ERASE_EN
        S_ERASE: begin
          if (bus.draw_done)   state_next = S_STEP;
          else if (wd_expired) begin
            state_next = S_IDLE;
            tmo_next   = 1'b1;
          end
        end
`endif
        S_STEP: state_next = S_DRAW;
        S_DRAW: begin
          if (bus.draw_done) begin
            idx_next   = frame_idx_q + 1'b1;
            state_next = (idx_next == FRAME_IDX_W'(NUM_FRAMES)) ? S_DONE : S_WAIT;
          end else if (wd_expired) begin
            state_next = S_IDLE;
            tmo_next   = 1'b1;
          end
        end
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      frame_idx_q <= '0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      step_q      <= 1'b0;
      draw_q      <= 1'b0;
      erase_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_next;
      frame_idx_q <= idx_next;
      timeout_q   <= tmo_next;
      busy_q      <= (state_next != S_IDLE);
      step_q      <= (state_next == S_STEP);
      draw_q      <= is_pass(state_next);
`ifdef ATTACK_SEQ_ERASE_EN
      erase_q     <= (state_next == S_ERASE);
`else
      erase_q     <= 1'b0;
`endif
      done_q      <= (state_next == S_DONE);
    end
  end

  assign bus.busy      = busy_q;
  assign bus.anim_en   = busy_q;
  assign bus.step_en   = step_q;
  assign bus.draw_en   = draw_q;
  assign bus.erase     = erase_q;
  assign bus.frame_idx = frame_idx_q;
  assign bus.move_done = done_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_attack_sequencer.sv
// Scoreboard bench for attack_sequencer with NUM_FRAMES=4, DRAW_TIMEOUT=16; a
// drawer model finishes each pass 5 cycles in unless told to hang.
module tb_attack_sequencer;
  import battle_pkg::*;

  localparam int NF = 4;
  localparam int TO = 16;
`ifdef ATTACK_SEQ_ERASE_EN
  localparam int ABORT_STEPS = 1;
`else
  localparam int ABORT_STEPS = 2;
`endif

  logic clock, reset;
  attack_sequencer_if bus();

  attack_sequencer #(.NUM_FRAMES(NF), .DRAW_TIMEOUT(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int steps = 0;
  int erase_hi = 0;
  int run_len = 0;
  int last_pass = 0;
  int hang_idx = -1;
  logic prev_draw_en = 1'b0;
  logic prev_done = 1'b0;
  logic [31:0] exp_idx[$];
  logic [31:0] exp_done[$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // Drawer: completes a pass on its 5th cycle of draw_en, except the hung frame.
  initial begin
    int pc;
    pc = 0;
    bus.draw_done = 1'b0;
    forever begin
      @(negedge clock);
      bus.draw_done = 1'b0;
      if (bus.draw_en && !reset) begin
        pc++;
        if (pc >= 5 && !(int'(bus.frame_idx) == hang_idx && !bus.erase)) begin
          bus.draw_done = 1'b1;
          pc = 0;
        end
      end else begin
        pc = 0;
      end
    end
  end

  // Output monitor: pops scoreboard entries as step_en / move_done appear.
  always @(negedge clock) begin
    if (reset) begin
      run_len = 0;
      prev_draw_en = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (bus.step_en) begin
        steps++;
        if (exp_idx.size() == 0) chk("step_unexp", 1, 0);
        else chk("step_idx", 32'(bus.frame_idx), exp_idx.pop_front());
      end
      if (bus.move_done) begin
        chk("done_lat", 32'(prev_draw_en), 1);
        if (exp_done.size() == 0) chk("done_unexp", 1, 0);
        else chk("done_idx", 32'(bus.frame_idx), exp_done.pop_front());
      end
      if (prev_done) chk("busy_fall", 32'(bus.busy), 0);
      if (bus.erase) erase_hi++;
      if (bus.draw_en) run_len++;
      else begin
        if (run_len != 0) last_pass = run_len;
        run_len = 0;
      end
      prev_draw_en = bus.draw_en;
      prev_done = bus.move_done;
    end
  end

  // mode: 0 normal, 1 dropped tick + mid-move start, 2 hang (timeout), 3 abort, 4 reset
  task automatic run_move(input int n_steps, input bit normal, input int mode, output int ticks);
    int budget, s0;
    bit seen_step, dropped, restarted, in_wait;
    logic [5:0] held;
    ticks = 0; seen_step = 0; dropped = 0; restarted = 0; s0 = steps;
    for (int i = 0; i < n_steps; i++) exp_idx.push_back(32'(i));
    if (normal) exp_done.push_back(32'(NF));
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("start_out", 32'({bus.busy, bus.anim_en, bus.draw_en, bus.erase}), 32'hE);
    chk("tmo_clr", 32'(bus.timeout), 0);
    chk("idx_clr", 32'(bus.frame_idx), 0);
    budget = 0;
    while (bus.busy && budget < 1500) begin
      budget++;
      if (bus.step_en) seen_step = 1;
      in_wait = bus.busy && !bus.draw_en && !bus.step_en && !bus.move_done;
`ifdef ATTACK_SEQ_ERASE_EN
      if (mode == 3 && bus.draw_done && bus.erase && bus.frame_idx == 6'd1) begin
`else
      if (mode == 3 && bus.draw_done && bus.draw_en && seen_step && bus.frame_idx == 6'd1) begin
`endif
        held = bus.frame_idx;
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_idle", 32'({bus.busy, bus.step_en, bus.draw_en, bus.move_done}), 0);
        chk("abort_idx", 32'(bus.frame_idx), 32'(held));
        break;
      end else if (mode == 4 && bus.step_en && bus.frame_idx == 6'd2) begin
        #2 reset = 1'b1;
        #1;
        chk("rst_async", 32'({bus.busy, bus.anim_en, bus.step_en, bus.draw_en, bus.erase,
                              bus.move_done, bus.timeout, bus.frame_idx}), 0);
        step();
        reset = 1'b0;
        break;
      end else if (mode == 1 && in_wait && bus.frame_idx == 6'd2 && !restarted) begin
        restarted = 1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("start_ign", 32'({bus.busy, bus.frame_idx}), 32'({1'b1, 6'd2}));
      end else if (in_wait) begin
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        ticks++;
`ifdef ATTACK_SEQ_ERASE_EN
        chk("tick_lat", 32'({bus.draw_en, bus.erase}), 32'h3);
`else
        chk("tick_lat", 32'(bus.step_en), 1);
`endif
      end else if (mode == 1 && !dropped && seen_step && bus.draw_en && !bus.erase && !bus.draw_done) begin
        dropped = 1;
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        ticks++;
        chk("drop_tick", 32'({bus.step_en, bus.draw_en}), 32'h1);
      end else begin
        step();
      end
    end
    chk("move_budget", 32'(budget < 1500), 1);
    repeat (3) step();
    chk("steps", 32'(steps - s0), 32'(n_steps));
    chk("sb_left", 32'(exp_idx.size() + exp_done.size()), 0);
    exp_idx.delete();
    exp_done.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL global_time obs=expired exp=finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int t;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.frame_tick = 1'b0;
    repeat (2) step();
    chk("rst_vals", 32'({bus.busy, bus.anim_en, bus.step_en, bus.draw_en, bus.erase,
                         bus.move_done, bus.timeout, bus.frame_idx}), 0);
    reset = 1'b0;

    run_move(NF, 1, 0, t);
    chk("ticks", 32'(t), 32'(NF));
    chk("final_idx", 32'({bus.busy, bus.frame_idx}), 32'(NF));

    run_move(NF, 1, 1, t);
    chk("drop_ticks", 32'(t), 32'(NF + 1));

    hang_idx = 1;
    run_move(2, 0, 2, t);
    hang_idx = -1;
    chk("timeout", 32'({bus.timeout, bus.busy}), 32'h2);
    chk("tmo_len", 32'(last_pass), 32'(TO));
    chk("tmo_idx", 32'(bus.frame_idx), 1);

    run_move(NF, 1, 0, t);
    chk("after_tmo_idx", 32'(bus.frame_idx), 32'(NF));

    run_move(ABORT_STEPS, 0, 3, t);
    chk("abort_tmo", 32'(bus.timeout), 0);

    run_move(3, 0, 4, t);
    run_move(NF, 1, 0, t);
    chk("post_rst_idx", 32'(bus.frame_idx), 32'(NF));

`ifdef ATTACK_SEQ_ERASE_EN
    chk("erase_seen", 32'(erase_hi != 0), 1);
`else
    chk("erase_hi", 32'(erase_hi), 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/attack_sequencer.md
# attack_sequencer

Moore FSM that sequences the sprite-attack datapath for one battle move: frame generator, position stepper and sprite drawer. On a `start` pulse it draws the initial sprite, then for each animation frame optionally erases the old sprite, advances position one step and redraws, for `NUM_FRAMES` frames, then reports completion. It sits between the battle control FSM and the per-move animation datapath, replacing free-running enables with an ordered erase/step/draw handshake.

## Interface
- `NUM_FRAMES`, default 50: frames per move; legal range 2..63.
- `DRAW_TIMEOUT`, default 4096: maximum cycles allowed in one draw or erase pass before abort.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces IDLE and all outputs to reset values.
- `start`  in  1  one-cycle request to begin a move; ignored unless in IDLE.
- `abort`  in  1  level; any non-IDLE state returns to IDLE next edge.
- `frame_tick`  in  1  one-cycle pulse from the frame-rate counter.
- `draw_done`  in  1  drawer finished current pass.
- `busy`  out  1  high in every state except IDLE.
- `anim_en`  out  1  enables frame-rate counter; high while busy.
- `step_en`  out  1  one-cycle pulse to the position stepper.
- `draw_en`  out  1  held high through a draw or erase pass.
- `erase`  out  1  high during erase pass (drawer outputs background colour).
- `frame_idx`  out  6  frames completed in the current move.
- `move_done`  out  1  one-cycle pulse on normal completion.
- `timeout`  out  1  sticky; set by watchdog expiry.

## Operation
- States: IDLE, DRAW0, WAIT, ERASE, STEP, DRAW, DONE.
- IDLE: `start` -> DRAW0; clear `frame_idx`, clear `timeout`.
- DRAW0: `draw_en`=1, `erase`=0; `draw_done` -> WAIT.
- WAIT: `frame_tick` -> ERASE (or STEP, see Configuration). Ticks outside WAIT are dropped, not queued.
- ERASE: `draw_en`=1, `erase`=1; `draw_done` -> STEP.
- STEP: `step_en`=1 for exactly this cycle -> DRAW.
- DRAW: `draw_en`=1, `erase`=0; `draw_done` -> `frame_idx`+1. If the new value equals `NUM_FRAMES`, go to DONE, otherwise go to WAIT.
- DONE: `move_done`=1 for one cycle -> IDLE.
- Every pass is separated by at least one cycle with `draw_en`=0, so the drawer restarts cleanly.
- Watchdog: counter is cleared on entry to DRAW0/ERASE/DRAW and increments each cycle in those states. On reaching `DRAW_TIMEOUT`-1 without `draw_done`: set `timeout`, go to IDLE, no `move_done`.
- `abort` has priority over `draw_done`, `frame_tick` and watchdog. It goes to IDLE with no `move_done`; `frame_idx` holds its value; `timeout` is unchanged.
- `start` while busy: ignored. `start` together with `abort` in IDLE: start is accepted.

## Timing
- All outputs registered. Reset values: `busy`, `anim_en`, `step_en`, `draw_en`, `erase`, `move_done`, `timeout` = 0; `frame_idx` = 0.
- `start` at edge N: `busy`/`anim_en`/`draw_en` high after edge N+1.
- `draw_done` at edge N: `draw_en` low after edge N+1.
- `frame_tick` in WAIT to `step_en`: 1 cycle without erase; erase pass + 1 cycle with erase.
- STEP to `draw_en` high: 1 cycle.
- Last `draw_done` to `move_done`: 1 cycle. `busy` falls the cycle after `move_done`.
- Reset asserted mid-move: immediate IDLE; the stepper's own reset is the system's responsibility.

## Configuration
- `ATTACK_SEQ_ERASE_EN` defined: ERASE state present, and WAIT goes to ERASE.
- `ATTACK_SEQ_ERASE_EN` undefined: ERASE is removed, WAIT goes directly to STEP, and `erase` is tied to 0. All other behaviour is identical.

## Structure
- Shared package `battle_pkg`: state enum `atk_state_t`, `FRAME_IDX_W`=6, default `NUM_FRAMES` and `DRAW_TIMEOUT` constants.
- One sub-module, `seq_watchdog`: loadable up-counter with `clear`, `run` and `expired` ports, width `$clog2(DRAW_TIMEOUT)`.

## Test plan
Bench parameters: `NUM_FRAMES`=4, `DRAW_TIMEOUT`=16.
- Normal move, erase on, drawer done 5 cycles after `draw_en`: 1 DRAW0 + 4×(ERASE, STEP, DRAW) passes. Expect 4 `step_en` pulses, `frame_idx` 0→4, one `move_done`, then `busy`=0.
- Erase off build, same stimulus: no `erase` high ever, `step_en` 1 cycle after each accepted `frame_tick`.
- `frame_tick` during DRAW: dropped, so the move takes one extra tick; `frame_tick` during WAIT accepted. `start` mid-move: no effect.
- Drawer never asserts `draw_done` in frame 2: `timeout`=1 after 16 cycles in DRAW, IDLE, no `move_done`. Next `start` clears `timeout`.
- `abort` in the same cycle as `draw_done` in ERASE: IDLE next cycle, no `step_en`, `frame_idx` held.
- `reset` asserted asynchronously mid-STEP: all outputs 0 before the next clock edge; a subsequent `start` runs a full 4-frame move.
